acc_feeder: RTL

Synthesizable transmitter for the accumulator valid/value channel: replaces the Lua-driven stub on the `valid`/`value` side of the accumulator in the top-level harness. Buffers accumulate requests from a ready/valid push interface in a FIFO and issues them as single-cycle `valid` pulses, gated by a start cycle and a minimum inter-issue gap. Optionally shadows the accumulator and flags divergence between the expected and observed running sum.

---
 rtl/acc_feeder_pkg.sv | 13 +
 rtl/acc_feeder_fifo.sv | 49 ++++
 rtl/acc_feeder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/acc_feeder_pkg.sv
// Shared types and widths for the accumulator feeder.
package acc_feeder_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CYCLE_W = 64;

  typedef enum logic [1:0] {
    ST_WAIT_START = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_GAP        = 2'd2
  } state_t;

endpackage

// File: rtl/acc_feeder_fifo.sv
// Synchronous FIFO holding pending addends; DEPTH must be a power of two.
module acc_feeder_fifo
  import acc_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_pop,
  output logic [DATA_W-1:0]           o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/acc_feeder.sv
// Accumulator feeder: FIFO-buffered addends issued as single-cycle valid pulses.
// Optional running-sum shadow checker enabled by defining ACC_FEEDER_CHECK_EN.
module acc_feeder
  import acc_feeder_pkg::*;
#(
  parameter int unsigned          DEPTH       = 8,
  parameter int unsigned          GAP         = 0,
  parameter logic [CYCLE_W-1:0]   START_CYCLE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CYCLE_W-1:0]   cycles,
  input  logic [DATA_W-1:0]    accumulator,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 valid,
  output logic [DATA_W-1:0]    value,
  output logic                 busy,
  output logic [31:0]          issued_count,
  output logic                 mismatch
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_W-1:0]      w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   r_valid;
  logic [DATA_W-1:0]      r_value;
  logic [31:0]            r_issued_count;
  logic [31:0]            r_gap_cnt;

  acc_feeder_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_WAIT_START;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_START: if (cycles >= START_CYCLE) w_state_nxt = ST_ISSUE;
      ST_ISSUE:      if (!w_empty && (GAP != 0)) w_state_nxt = ST_GAP;
      ST_GAP:        if (r_gap_cnt <= 32'd1) w_state_nxt = ST_ISSUE;
      default:       w_state_nxt = ST_WAIT_START;
    endcase
  end

  always_comb begin
    w_pop = (r_state == ST_ISSUE) && !w_empty;
  end

  // The pulse cycle itself counts as the first GAP cycle, so loading GAP and
  // leaving at 1 yields exactly GAP idle cycles between pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_value        <= '0;
      r_issued_count <= '0;
      r_gap_cnt      <= '0;
    end else begin
      r_valid        <= w_pop;
      if (w_pop) r_value <= w_head;
      r_issued_count <= r_issued_count + 32'(r_valid);
      if (w_pop && (GAP != 0))
        r_gap_cnt <= 32'(GAP);
      else if ((r_state == ST_GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - 32'd1;
    end
  end

  assign in_ready     = !w_full;
  assign valid        = r_valid;
  assign value        = r_value;
  assign issued_count = r_issued_count;
  assign busy         = (w_count != '0) || r_valid || (r_gap_cnt != '0);

`ifdef ACC_FEEDER_CHECK_EN
  logic              r_armed;
  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_exp_sum;
  logic              r_mismatch;

  // Base is sampled on the first post-reset cycle; comparison starts one later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_base     <= '0;
      r_exp_sum  <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (!r_armed) r_base <= accumulator;
      if (r_valid)  r_exp_sum <= r_exp_sum + r_value;
      if (r_armed && ((accumulator - r_base) != r_exp_sum)) r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_acc;
  assign w_unused_acc = ^accumulator;
  assign mismatch     = 1'b0;
`endif

endmodule
